// File: rtl/ov5642_pkg.sv
// Shared types and constants for the OV5642 camera capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: capture FSM state enum, default line/frame geometry,
// resolution presets shared with the parallel receiver, saturating helper.
package ov5642_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DROP     = 2'd3
  } cap_state_e;

  // 1280 px x 2 B per line (RGB565/YUV422), 720 lines per frame.
  localparam int DEF_H_BYTES = 2560;
  localparam int DEF_V_LINES = 720;
  localparam int DEF_CNT_W   = 16;

  // Geometry presets in bytes per line / lines per frame at 2 B per pixel.
  typedef struct packed {
    logic [15:0] h_bytes;
    logic [15:0] v_lines;
  } res_preset_t;

  localparam res_preset_t RES_VGA   = '{h_bytes: 16'd1280, v_lines: 16'd480};
  localparam res_preset_t RES_720P  = '{h_bytes: 16'd2560, v_lines: 16'd720};
  localparam res_preset_t RES_1080P = '{h_bytes: 16'd3840, v_lines: 16'd1080};
  localparam res_preset_t RES_5MP   = '{h_bytes: 16'd5184, v_lines: 16'd1944};

  // Frame counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ov5642_sync_edge.sv
// Registers raw href/vsync and flags their rising/falling edges.
// Latency: edge pulses are combinational against a 1-cycle delayed copy.
// Backpressure: none; the camera syncs free-run.
//
// Ports: clk/rst_n (async active-low), href/vsync raw syncs in,
// href_rise/href_fall/vsync_rise/vsync_fall single-cycle pulses out.
module ov5642_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic href,
  input  logic vsync,
  output logic href_rise,
  output logic href_fall,
  output logic vsync_rise,
  output logic vsync_fall
);

  logic href_q, href_d;
  logic vsync_q, vsync_d;

  always_comb begin
    href_d  = href;
    vsync_d = vsync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= href_d;
      vsync_q <= vsync_d;
    end
  end

  assign href_rise  =  href  & ~href_q;
  assign href_fall  = ~href  &  href_q;
  assign vsync_rise =  vsync & ~vsync_q;
  assign vsync_fall = ~vsync &  vsync_q;

endmodule

// File: rtl/ov5642_capture_ctrl.sv
// Frame-aligned capture gate between the OV5642 receiver stream and frame DMA.
// Latency: 1 cycle s_tvalid -> m_tvalid through a single output register.
// Backpressure: source cannot stall; a beat arriving on a held output is lost, err_overflow set, rest of frame dropped.
//
// Ports: start/stop/num_frames/clear_err control; href/vsync raw syncs for
// geometry checks; s_* receiver stream (no tready); m_* DMA stream with
// m_tuser = start-of-frame; busy, frame_done, frames_captured, sticky errors.
module ov5642_capture_ctrl
  import ov5642_pkg::*;
#(
  parameter int H_BYTES = DEF_H_BYTES,
  parameter int V_LINES = DEF_V_LINES,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic       pclk,
  input  logic       aresetn,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] num_frames,
  input  logic       clear_err,
  input  logic       href,
  input  logic       vsync,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frames_captured,
  output logic       err_overflow,
  output logic       err_size
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] H_BYTES_C = CNT_W'(H_BYTES);
  localparam logic [CNT_W-1:0] V_LINES_C = CNT_W'(V_LINES);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  cap_state_e       state_q, state_d;
  logic [7:0]       num_frames_q, num_frames_d;
  logic [7:0]       frames_captured_q, frames_captured_d;
  logic [CNT_W-1:0] line_byte_cnt_q, line_byte_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             sof_pending_q, sof_pending_d;
  logic             stop_pending_q, stop_pending_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_size_q, err_size_d;
  logic             frame_done_q, frame_done_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tlast_q, m_tlast_d;
  logic             m_tuser_q, m_tuser_d;
  logic [7:0]       m_tdata_q, m_tdata_d;

  logic             href_rise, href_fall, vsync_fall;
  logic             unused_vsync_rise;
  logic             can_load, stop_now, target_next, target_met;
  logic [CNT_W-1:0] lines_seen;

  ov5642_sync_edge u_sync_edge (
    .clk        (pclk),
    .rst_n      (aresetn),
    .href       (href),
    .vsync      (vsync),
    .href_rise  (href_rise),
    .href_fall  (href_fall),
    .vsync_rise (unused_vsync_rise),
    .vsync_fall (vsync_fall)
  );

  always_comb begin
    state_d           = state_q;
    num_frames_d      = num_frames_q;
    frames_captured_d = frames_captured_q;
    line_byte_cnt_d   = line_byte_cnt_q;
    line_cnt_d        = line_cnt_q;
    sof_pending_d     = sof_pending_q;
    stop_pending_d    = stop_pending_q;
    err_overflow_d    = err_overflow_q;
    err_size_d        = err_size_q;
    frame_done_d      = 1'b0;
    m_tvalid_d        = m_tvalid_q;
    m_tlast_d         = m_tlast_q;
    m_tuser_d         = m_tuser_q;
    m_tdata_d         = m_tdata_q;
    lines_seen        = '0;

    // Clear first so an error arriving in the same cycle still wins.
    if (clear_err) begin
      err_overflow_d = 1'b0;
      err_size_d     = 1'b0;
    end

    // Held beat retires on handshake; a new load below overrides this.
    if (m_tvalid_q && m_tready) m_tvalid_d = 1'b0;

    // Byte counter includes the rising-edge cycle itself, so a line of N
    // href-high cycles reads N on the falling edge.
    if (href_rise)  line_byte_cnt_d = CNT_W'(1);
    else if (href)  line_byte_cnt_d = cnt_inc(line_byte_cnt_q);

    can_load    = !m_tvalid_q || m_tready;
    stop_now    = stop_pending_q || stop;
    target_next = (num_frames_q != 8'd0) && (frames_captured_q + 8'd1 == num_frames_q);
    target_met  = (num_frames_q != 8'd0) && (frames_captured_q >= num_frames_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          num_frames_d      = num_frames;
          frames_captured_d = 8'd0;
          state_d           = ST_WAIT_SOF;
        end
      end

      ST_WAIT_SOF: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (vsync_fall) begin
          line_cnt_d    = '0;
          sof_pending_d = 1'b1;
          state_d       = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (stop) stop_pending_d = 1'b1;
        if (href_fall) begin
          line_cnt_d = cnt_inc(line_cnt_q);
          if (line_byte_cnt_q != H_BYTES_C) err_size_d = 1'b1;
        end
        if (s_tvalid) begin
          if (can_load) begin
            m_tvalid_d    = 1'b1;
            m_tdata_d     = s_tdata;
            m_tlast_d     = s_tlast;
            m_tuser_d     = sof_pending_q;
            sof_pending_d = 1'b0;
            if (s_tlast) begin
              // The last byte normally arrives with href still high, so
              // its line has not been closed by a falling edge yet: close
              // it here and check its length before judging the frame.
              if (href) begin
                lines_seen = cnt_inc(line_cnt_d);
                if (line_byte_cnt_d != H_BYTES_C) err_size_d = 1'b1;
              end else begin
                lines_seen = line_cnt_d;
              end
              if (lines_seen != V_LINES_C) err_size_d = 1'b1;
              frame_done_d      = 1'b1;
              frames_captured_d = sat_inc8(frames_captured_q);
              state_d           = (stop_now || target_next) ? ST_IDLE : ST_WAIT_SOF;
            end
          end else begin
            // Output register still owned by DMA: this beat is lost.
            err_overflow_d = 1'b1;
            if (s_tlast) state_d = (stop_now || target_met) ? ST_IDLE : ST_WAIT_SOF;
            else         state_d = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        if (stop) stop_pending_d = 1'b1;
        if (s_tvalid && s_tlast) state_d = (stop_now || target_met) ? ST_IDLE : ST_WAIT_SOF;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) stop_pending_d = 1'b0;
  end

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q           <= ST_IDLE;
      num_frames_q      <= 8'd0;
      frames_captured_q <= 8'd0;
      line_byte_cnt_q   <= '0;
      line_cnt_q        <= '0;
      sof_pending_q     <= 1'b0;
      stop_pending_q    <= 1'b0;
      err_overflow_q    <= 1'b0;
      err_size_q        <= 1'b0;
      frame_done_q      <= 1'b0;
      m_tvalid_q        <= 1'b0;
      m_tlast_q         <= 1'b0;
      m_tuser_q         <= 1'b0;
      m_tdata_q         <= 8'd0;
    end else begin
      state_q           <= state_d;
      num_frames_q      <= num_frames_d;
      frames_captured_q <= frames_captured_d;
      line_byte_cnt_q   <= line_byte_cnt_d;
      line_cnt_q        <= line_cnt_d;
      sof_pending_q     <= sof_pending_d;
      stop_pending_q    <= stop_pending_d;
      err_overflow_q    <= err_overflow_d;
      err_size_q        <= err_size_d;
      frame_done_q      <= frame_done_d;
      m_tvalid_q        <= m_tvalid_d;
      m_tlast_q         <= m_tlast_d;
      m_tuser_q         <= m_tuser_d;
      m_tdata_q         <= m_tdata_d;
    end
  end

  assign m_tdata         = m_tdata_q;
  assign m_tvalid        = m_tvalid_q;
  assign m_tlast         = m_tlast_q;
  assign m_tuser         = m_tuser_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = frame_done_q;
  assign frames_captured = frames_captured_q;
  assign err_overflow    = err_overflow_q;
  assign err_size        = err_size_q;

endmodule
